// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple-dual-port RAM with byte enables, 1/2-cycle read latency and post-reset clear sweep
module sdp_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_BYTES-1:0]  wr_be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
      $error("sdp_ram_be: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("sdp_ram_be: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range, rd_in_range;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  p_valid;
  logic [DATA_WIDTH-1:0] p_data;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign wr_accept   = we && (state == READY) && wr_in_range;
  assign rd_accept   = re && (state == READY);
  assign busy        = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == LAST_ADDR) state <= READY;
    end
  end

  // Array has no reset; the sweep is the only way contents get initialised.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= CLEAR_VALUE;
      end else if (wr_accept) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Write-first mode forwards enabled bytes of a colliding write into the read word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == 1 && wr_accept && (wr_addr == rd_addr)) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (wr_be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid  <= 1'b0;
      p_data   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      p_valid <= rd_accept;
      if (rd_accept) p_data <= rd_word;
      if (RD_LATENCY == 1) begin
        rd_valid <= rd_accept;
        if (rd_accept) rd_data <= rd_word;
      end else begin
        rd_valid <= p_valid;
        if (p_valid) rd_data <= p_data;
      end
    end
  end

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb/tb_sdp_ram_be.sv - three sdp_ram_be configurations driven in lockstep against an array/queue reference model
module tb_sdp_ram_be;

  localparam int NI = 3;
  localparam logic [15:0] CV = 16'hA5A5;

  int dep [NI] = '{64, 64, 48};
  int lat [NI] = '{1, 2, 2};
  int rdw [NI] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [5:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] rd_data [NI];
  logic        rd_valid [NI];
  logic        busy [NI];

  always #5 clk = ~clk;

  sdp_ram_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64), .RD_LATENCY(1),
               .RDW_MODE(0), .CLEAR_VALUE(CV)) u_d0 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .busy(busy[0]));

  sdp_ram_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64), .RD_LATENCY(2),
               .RDW_MODE(1), .CLEAR_VALUE(CV)) u_d1 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .busy(busy[1]));

  sdp_ram_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48), .RD_LATENCY(2),
               .RDW_MODE(0), .CLEAR_VALUE(CV)) u_d2 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .busy(busy[2]));

  typedef struct {
    int          k;
    int          due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] mm [NI][64];
  int          clear_left [NI];
  logic [15:0] exp_data [NI];
  logic        exp_valid [NI];
  rd_t         q [$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: advance the reference model with the inputs seen at that edge, then compare.
  task automatic step();
    logic [15:0] rv;
    rd_t         nq [$];
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        clear_left[k] = dep[k];
        exp_valid[k]  = 1'b0;
        exp_data[k]   = 16'h0000;
        nq = {};
        foreach (q[j]) if (q[j].k != k) nq.push_back(q[j]);
        q = nq;
      end else if (clear_left[k] > 0) begin
        mm[k][dep[k] - clear_left[k]] = CV;
        clear_left[k]--;
        exp_valid[k] = 1'b0;
      end else begin
        if (re) begin
          rv = 16'h0000;
          if (int'(rd_addr) < dep[k]) begin
            rv = mm[k][rd_addr];
            if (rdw[k] == 1 && we && wr_addr == rd_addr) begin
              if (wr_be[0]) rv[7:0]  = wr_data[7:0];
              if (wr_be[1]) rv[15:8] = wr_data[15:8];
            end
          end
          q.push_back('{k: k, due: cyc + lat[k] - 1, d: rv});
        end
        if (we && int'(wr_addr) < dep[k]) begin
          if (wr_be[0]) mm[k][wr_addr][7:0]  = wr_data[7:0];
          if (wr_be[1]) mm[k][wr_addr][15:8] = wr_data[15:8];
        end
        exp_valid[k] = 1'b0;
        nq = {};
        foreach (q[j]) begin
          if (q[j].k == k && q[j].due == cyc) begin
            exp_valid[k] = 1'b1;
            exp_data[k]  = q[j].d;
          end else begin
            nq.push_back(q[j]);
          end
        end
        q = nq;
      end
      chk($sformatf("busy[%0d]", k), 16'(busy[k]), 16'(clear_left[k] > 0));
      chk($sformatf("rd_valid[%0d]", k), 16'(rd_valid[k]), 16'(exp_valid[k]));
      chk($sformatf("rd_data[%0d]", k), rd_data[k], exp_data[k]);
    end
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [5:0] a);
    re = 1'b1; rd_addr = a;
  endtask

  // Called just after the last rst=1 edge; counts busy samples until every instance is ready.
  task automatic wait_clear(input int noisy);
    int n [NI];
    for (int k = 0; k < NI; k++) n[k] = int'(busy[k]);
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (c < noisy) begin
        we = 1'($urandom); re = 1'($urandom);
        wr_addr = 6'($urandom); rd_addr = 6'($urandom);
        wr_data = 16'($urandom); wr_be = 2'($urandom);
      end else begin
        idle();
      end
      step();
      for (int k = 0; k < NI; k++) n[k] += int'(busy[k]);
    end
    for (int k = 0; k < NI; k++) chk($sformatf("busy_len[%0d]", k), 16'(n[k]), 16'(dep[k]));
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;

    repeat (3) step();
    wait_clear(40);

    rd(6'd0);  step(); chk("clr_rd0", rd_data[0], CV);
    rd(6'd31); step(); chk("clr_rd31", rd_data[0], CV);
    rd(6'd63); step(); chk("clr_rd63", rd_data[0], CV); chk("clr_rd63_v", 16'(rd_valid[0]), 16'd1);
    idle(); step(); step();

    wr(6'd5, 16'h1234, 2'b11); step();
    wr(6'd5, 16'hFFEE, 2'b01); step();
    idle(); rd(6'd5); step(); chk("be_merge_d0", rd_data[0], 16'h12EE);
    idle(); step(); chk("be_merge_d1", rd_data[1], 16'h12EE);
    wr(6'd5, 16'h0000, 2'b00); step();
    idle(); rd(6'd5); step(); chk("be_none_d0", rd_data[0], 16'h12EE);
    idle(); step();

    wr(6'd7, 16'h0001, 2'b11); step();
    wr(6'd7, 16'hBEEF, 2'b11); rd(6'd7); step(); chk("rdw_old_d0", rd_data[0], 16'h0001);
    idle(); step(); chk("rdw_new_d1", rd_data[1], 16'hBEEF);
    wr(6'd7, 16'h0001, 2'b11); step();
    wr(6'd7, 16'hBEEF, 2'b10); rd(6'd7); step();
    idle(); step(); chk("rdw_byte_d1", rd_data[1], 16'hBE01);
    step();

    for (int a = 0; a < 4; a++) begin
      rd(6'(a)); step();
      chk($sformatf("lat1_v%0d", a), 16'(rd_valid[0]), 16'd1);
      chk($sformatf("lat2_v%0d", a), 16'(rd_valid[1]), 16'(a > 0));
    end
    idle(); step();
    chk("lat2_tail_v", 16'(rd_valid[1]), 16'd1);
    chk("lat2_tail_d", rd_data[1], CV);
    chk("lat1_tail_v", 16'(rd_valid[0]), 16'd0);

    wr(6'd63, 16'h3C3C, 2'b11); step();
    idle(); rd(6'd63); step(); chk("top_addr_d0", rd_data[0], 16'h3C3C);
    idle(); step(); chk("oor_d2_data", rd_data[2], 16'h0000); chk("oor_d2_v", 16'(rd_valid[2]), 16'd1);
    wr(6'd50, 16'h7777, 2'b11); step();
    idle(); rd(6'd50); step();
    idle(); step(); chk("oor_wr_d2", rd_data[2], 16'h0000);

    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom); re = 1'($urandom);
      wr_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 7));
      rd_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 7));
      wr_data = 16'($urandom); wr_be = 2'($urandom);
      step();
    end
    idle(); step(); step();

    rst = 1'b1; step();
    rst = 1'b0; repeat (20) step();
    rst = 1'b1; step();
    wait_clear(0);

    rd(6'd1); step();
    idle(); rst = 1'b1; step();
    chk("flush_d1_v", 16'(rd_valid[1]), 16'd0);
    chk("flush_d2_v", 16'(rd_valid[2]), 16'd0);
    wait_clear(30);

    wr(6'd9, 16'hC0DE, 2'b11); step();
    for (int a = 0; a < 64; a++) begin
      idle(); rd(6'(a)); step();
    end
    idle(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
